// File: rtl/miriscv_fetch.sv
// Instruction fetch: one outstanding memory request, output register plus one-entry skid buffer.
// A response lands in the output one edge after it arrives; a stall with the output full parks it in the buffer and stops requesting.
module miriscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fetched_valid_o,
  output logic [31:0] fetched_instr_o,
  output logic [31:0] fetched_pc_o,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    FULL  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic [31:0] redirect_target;

  logic        resp;
  logic        consumed;
  logic        load_out_mem;
  logic        load_out_buf;
  logic        load_buf;

  assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = REQ;
      REQ:   if (resp) state_nxt = VALID;
      VALID: begin
        if (resp && !consumed) begin
          state_nxt = FULL;
        end else if (!resp && consumed) begin
          state_nxt = REQ;
        end
      end
      FULL:  if (consumed) state_nxt = VALID;
      default: state_nxt = IDLE;
    endcase
    // Redirect restarts fetching from any state, IDLE included.
    if (redirect_i) begin
      state_nxt = REQ;
    end
  end

  always_comb begin
    instr_req_o     = ((state == REQ) || (state == VALID)) && !redirect_i;
    fetched_valid_o = (state == VALID) || (state == FULL);
    resp            = instr_req_o && instr_rvalid_i;
    consumed        = fetched_valid_o && !stall_i;
    load_out_mem    = resp && ((state == REQ) || consumed);
    load_buf        = resp && (state == VALID) && !consumed;
    load_out_buf    = (state == FULL) && consumed && !redirect_i;
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      pc        <= RESET_PC;
      out_instr <= NOP;
      out_pc    <= RESET_PC;
      buf_instr <= NOP;
      buf_pc    <= RESET_PC;
    end else if (redirect_i) begin
      pc        <= redirect_target;
      out_instr <= NOP;
    end else begin
      if (resp) begin
        pc <= pc + 32'd4;
      end
      if (load_out_mem) begin
        out_instr <= instr_rdata_i;
        out_pc    <= pc;
      end else if (load_out_buf) begin
        out_instr <= buf_instr;
        out_pc    <= buf_pc;
      end
      if (load_buf) begin
        buf_instr <= instr_rdata_i;
        buf_pc    <= pc;
      end
    end
  end

  assign instr_addr_o    = pc;
  assign fetched_instr_o = out_instr;
  assign fetched_pc_o    = out_pc;

endmodule

// File: doc/miriscv_fetch.md
# miriscv_fetch

Instruction fetch stage for the miriscv core: drives the instruction-memory request interface and presents fetched instructions, with their PCs, to `miriscv_decode` through a valid/stall handshake. Holds one prefetched instruction in a skid buffer so a stalled decoder does not stop the memory access already in flight. Branch/jump redirects from execute flush all fetched state and restart fetching at the target.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `arstn_i`  in  1  reset; synchronous and active-low.
- `instr_req_o`  out  1  instruction-memory request.
- `instr_addr_o`  out  32  request address; bits [1:0] always 0.
- `instr_rvalid_i`  in  1  response valid; completes the request in any cycle it is high while `instr_req_o` is high, including the same cycle.
- `instr_rdata_i`  in  32  instruction word, valid with `instr_rvalid_i`.
- `fetched_valid_o`  out  1  `fetched_instr_o` and `fetched_pc_o` hold a live instruction.
- `fetched_instr_o`  out  32  instruction for decode.
- `fetched_pc_o`  out  32  address of `fetched_instr_o`.
- `stall_i`  in  1  decode cannot accept; the instruction is consumed in any cycle with `fetched_valid_o=1` and `stall_i=0`.
- `redirect_i`  in  1  flush and restart at `redirect_pc_i`.
- `redirect_pc_i`  in  32  redirect target; bits [1:0] ignored (forced to 0).

## Operation
- Registers: `pc` (next fetch address), output register (instr, pc), one-entry buffer (instr, pc), state.
- `instr_addr_o = pc`. `instr_req_o = 1` in REQ and VALID, `0` in IDLE and FULL, and forced to 0 in any cycle with `redirect_i=1`.
- IDLE: reached from reset; unconditionally go to REQ next cycle.
- REQ (output empty, request outstanding):
  - `rvalid`: output <= (rdata, pc); `pc <= pc+4`; go to VALID.
- VALID (output occupied, next request outstanding). Let `consumed = !stall_i`.
  - `rvalid` and `consumed`: output <= (rdata, pc); `pc += 4`; stay in VALID.
  - `rvalid` and not `consumed`: buffer <= (rdata, pc); `pc += 4`; go to FULL.
  - `consumed` only: go to REQ.
  - neither: hold.
- FULL (output and buffer occupied, no request):
  - `consumed`: output <= buffer; go to VALID. Otherwise hold.
- Redirect has priority over everything, in any state except IDLE:
  - `pc <= {redirect_pc_i[31:2],2'b00}`.
  - Output and buffer are invalidated, and `fetched_instr_o` is set to 32'h0000_0013 (NOP).
  - Go to REQ.
  - An `rvalid` in the redirect cycle cannot occur (no request is presented); if it does, it is ignored.
- Redirect in IDLE: updates `pc`; the state still goes to REQ.
- `fetched_valid_o = 1` in VALID and FULL only.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Instruction content is never inspected; illegal encodings pass through to decode.

## Timing
- Reset (`arstn_i=0` at an edge), applicable mid-operation, discards all state:
  - state = IDLE, `pc` = `RESET_PC`.
  - `instr_req_o=0`, `instr_addr_o=RESET_PC`.
  - `fetched_valid_o=0`, `fetched_instr_o=32'h0000_0013`, `fetched_pc_o=RESET_PC`.
- First `instr_req_o=1` occurs in the second cycle after reset deassertion (IDLE, then REQ).
- Latency: with `rvalid` in the request cycle, `fetched_valid_o` rises on the next edge.
- Throughput with zero-wait memory and no stall: one instruction per cycle in steady state.
- `instr_addr_o` is stable while `instr_req_o=1` and no `rvalid` or redirect occurs.
- With `redirect_i` at edge N: the request for the target is issued in cycle N+1, and `fetched_valid_o=0` in cycle N+1.
- `stall_i` is ignored when `fetched_valid_o=0`.
- At most one outstanding request and at most two fetched instructions held at once; no instruction is dropped or duplicated except by redirect.

## Test plan
- Reset then zero-wait memory returning `addr^32'hA5A5_0000`, `stall_i=0` -> `instr_req_o` first high in cycle 2 at 0x0; `fetched_pc_o` sequence 0x0, 0x4, 0x8… one per cycle; instr matches.
- `stall_i=1` for 3 cycles while valid at PC 0x8 -> FULL entered with buffer PC 0xC; `instr_req_o=0`; output holds 0x8; after release 0x8, 0xC, 0x10 each appear exactly once, in order.
- Random `rvalid` delay of 0–4 cycles plus random stall -> decoded PC stream is a strictly +4 sequence with no gaps or duplicates; address stable while waiting.
- `redirect_i=1` with `redirect_pc_i=32'h0000_0103` while in FULL -> next cycle `fetched_valid_o=0`, `instr_addr_o=0x100`; next valid PC is 0x100; buffered instructions never appear.
- Redirect and stall in the same cycle, and `RESET_PC=32'hFFFF_FFF8` -> redirect wins; PCs wrap FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `arstn_i=0` for one cycle in VALID with a request outstanding -> all outputs at reset values next cycle; fetch restarts at `RESET_PC`.
